// File: rtl/alu_rr_sched.sv
// Round-robin scheduler that time-shares one combinational ALU slice among NREQ requesters.
// Each granted op runs IDLE (accept) -> EXEC (ALU drive) -> RESP (hold result until taken).
module alu_rr_sched #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREQ = 2,
    parameter int unsigned OPW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OPW-1:0]  req_op,
    input  logic [NREQ*XLEN-1:0] req_rs1,
    input  logic [NREQ*XLEN-1:0] req_rs2,
    output logic [OPW-1:0]       alu_op,
    output logic [XLEN-1:0]      alu_rs1,
    output logic [XLEN-1:0]      alu_rs2,
    input  logic [XLEN-1:0]      alu_rd,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]      rsp_rd
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [IW-1:0]   winner;
    logic            any_valid;
    logic [IW:0]     cand;
    logic [IW:0]     ptr_next;
    logic            accept;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Search starts at ptr and wraps, so the most recently served requester is tried last.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!any_valid && req_valid[cand[IW-1:0]]) begin
                any_valid = 1'b1;
                winner    = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        ptr_next = {1'b0, winner} + (IW+1)'(1);
        if (ptr_next >= (IW+1)'(NREQ)) begin
            ptr_next = ptr_next - (IW+1)'(NREQ);
        end
    end

    assign accept = (state_q == StIdle) && any_valid && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready = onehot(winner);
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        op_d     = op_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    op_d    = req_op[winner*OPW +: OPW];
                    rs1_d   = req_rs1[winner*XLEN +: XLEN];
                    rs2_d   = req_rs2[winner*XLEN +: XLEN];
                    grant_d = winner;
                    ptr_d   = ptr_next[IW-1:0];
                    state_d = StExec;
                end
            end
            StExec: begin
                result_d = alu_rd;
                state_d  = StResp;
            end
            StResp: begin
                // Only the granted requester's rsp_ready completes the response.
                if (rsp_ready[grant_q]) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            grant_q  <= '0;
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            result_q <= result_d;
        end
    end

    // The shared ALU always sees the latched operands; rs2 goes out unmasked.
    assign alu_op  = op_q;
    assign alu_rs1 = rs1_q;
    assign alu_rs2 = rs2_q;
    assign rsp_rd  = result_q;

    always_comb begin
        rsp_valid = '0;
        if (state_q == StResp) begin
            rsp_valid = onehot(grant_q);
        end
    end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched with NREQ=2 and a shift-left-logical ALU model.
// Expected results are queued as stimulus is issued and retired on each response handshake.
module tb_alu_rr_sched;

    localparam int XLEN = 32;
    localparam int NREQ = 2;
    localparam int OPW  = 4;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [OPW-1:0]       op0, op1;
    logic [XLEN-1:0]      rs1_0, rs1_1, rs2_0, rs2_1;
    logic [OPW-1:0]       alu_op;
    logic [XLEN-1:0]      alu_rs1, alu_rs2, alu_rd;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [XLEN-1:0]      rsp_rd;

    typedef struct {
        int          id;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    alu_rr_sched #(.XLEN(XLEN), .NREQ(NREQ), .OPW(OPW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    ({op1, op0}),
        .req_rs1   ({rs1_1, rs1_0}),
        .req_rs2   ({rs2_1, rs2_0}),
        .alu_op    (alu_op),
        .alu_rs1   (alu_rs1),
        .alu_rs2   (alu_rs2),
        .alu_rd    (alu_rd),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rd    (rsp_rd)
    );

    // Shared ALU: shift left logical, amount taken from rs2[4:0].
    assign alu_rd = alu_rs1 << alu_rs2[4:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic [31:0] rd);
        exp_t e;
        e.id = id;
        e.rd = rd;
        exp_q.push_back(e);
    endtask

    // Retire one expectation per completed response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("rsp_id", 64'(i), 64'(e.id));
                        check("rsp_rd", 64'(rsp_rd), 64'(e.rd));
                        check("rsp_onehot", 64'(rsp_valid), 64'(2'b01 << i));
                    end
                end
            end
        end
    end

    task automatic run_grants(input int cnt, input int first);
        int n;
        for (int g = 0; g < cnt; g++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (req_ready == '0 && n < 12);
            check("grant", 64'(req_ready), 64'(2'b01 << ((first + g) % 2)));
            if (g > 0) check("spacing", 64'(n), 64'd3);
            @(posedge clk);
            #1;
            if (g == cnt - 1) req_valid = '0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        op0 = 4'h3; op1 = 4'h5;
        rs1_0 = '0; rs1_1 = '0; rs2_0 = '0; rs2_1 = '0;

        // 1. Asynchronous reset with no clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_alu_rs1", 64'(alu_rs1), 64'd0);
        check("rst_alu_rs2", 64'(alu_rs2), 64'd0);
        check("rst_rsp_rd", 64'(rsp_rd), 64'd0);
        #1 rst = 1'b0;

        // 2. Single request from requester 0
        @(posedge clk); #1;
        rs1_0 = 32'h5555_5555; rs2_0 = 32'd1; rsp_ready = 2'b11;
        req_valid = 2'b01;
        push(0, 32'hAAAA_AAAA);
        @(negedge clk);
        check("t2_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        rs1_0 = 32'h0;                         // post-accept change must not matter
        @(negedge clk);
        check("t2_exec_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t2_exec_req_ready", 64'(req_ready), 64'd0);
        check("t2_alu_rs1", 64'(alu_rs1), 64'h5555_5555);
        check("t2_alu_op", 64'(alu_op), 64'h3);
        @(negedge clk);
        check("t2_rsp_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_idle_rsp_valid", 64'(rsp_valid), 64'd0);
        drain();

        // 3. Raw shift amount from requester 1
        @(posedge clk); #1;
        rs1_1 = 32'h5555_5555; rs2_1 = 32'd72;
        req_valid = 2'b10;
        push(1, 32'h5555_5500);
        @(negedge clk);
        check("t3_req_ready", 64'(req_ready), 64'd2);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("t3_alu_rs2", 64'(alu_rs2), 64'd72);
        @(negedge clk);
        check("t3_rsp_valid", 64'(rsp_valid), 64'd2);
        drain();

        // 4. Contention: strict alternation
        @(posedge clk); #1;
        rs1_0 = 32'hFFFF_FFFF; rs2_0 = 32'd3;
        rs1_1 = 32'd1;         rs2_1 = 32'd10;
        push(0, 32'hFFFF_FFF8); push(1, 32'h0000_0400);
        push(0, 32'hFFFF_FFF8); push(1, 32'h0000_0400);
        req_valid = 2'b11;
        run_grants(4, 0);
        drain();

        // 5. Backpressure on requester 0; requester 1's rsp_ready must be ignored
        @(posedge clk); #1;
        rs1_0 = 32'd1; rs2_0 = 32'd4;
        rsp_ready = 2'b10;
        req_valid = 2'b01;
        push(0, 32'h0000_0010);
        push(1, 32'h0000_0400);
        @(posedge clk); #1;
        req_valid = 2'b10;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t5_rsp_valid", 64'(rsp_valid), 64'd1);
            check("t5_rsp_rd", 64'(rsp_rd), 64'h10);
            check("t5_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        check("t5_release_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_resume", 64'(req_ready), 64'd2);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // 6. Reset during EXEC of a requester-1 op
        @(posedge clk); #1;
        req_valid = 2'b10;
        @(negedge clk);
        check("t6_req_ready", 64'(req_ready), 64'd2);
        @(posedge clk); #1;
        req_valid = '0;
        #2 rst = 1'b1;
        #1;
        check("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t6_rst_alu_rs1", 64'(alu_rs1), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t6_no_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
        push(0, 32'h0000_0010);
        push(1, 32'h0000_0400);
        req_valid = 2'b11;
        run_grants(2, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
